// File: rtl/control_unit.sv
// Moore control FSM: sequences fetch, decode and execute phases of the 8-bit CPU
// and drives the datapath register enables, bus selects, ALU select and memory write.
module control_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write
);

  localparam logic [7:0] OP_LDA_IMM = 8'h86, OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88, OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96, OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB  = 8'h42, OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44, OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46, OP_INCB    = 8'h47;
  localparam logic [7:0] OP_DECA    = 8'h48, OP_DECB    = 8'h49;
  localparam logic [7:0] OP_BRA     = 8'h20, OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BEQ     = 8'h23, OP_BNE     = 8'h24;
  localparam logic [7:0] OP_BCS     = 8'h27;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011, ALU_INCA = 3'b100, ALU_DECA = 3'b101;
  localparam logic [2:0] ALU_INCB = 3'b110, ALU_DECB = 3'b111;

  localparam logic [1:0] BUS1_PC = 2'b00, BUS1_A = 2'b01, BUS1_B = 2'b10;
  localparam logic [1:0] BUS2_ALU = 2'b00, BUS2_BUS1 = 2'b01, BUS2_MEM = 2'b10;

  // ALU operations get one state each so ALU_Sel is a pure function of state
  typedef enum logic [5:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
    S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
    S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
    S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
    S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
    S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
    S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
    S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4,
    S_INCA_4, S_INCB_4, S_DECA_4, S_DECB_4,
    S_BR_4, S_BR_5, S_BR_6, S_BR_NT_4
  } state_t;

  state_t state, next_state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_FETCH_0;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH_0;
    IR_Load    = 1'b0;
    MAR_Load   = 1'b0;
    PC_Load    = 1'b0;
    PC_Inc     = 1'b0;
    A_Load     = 1'b0;
    B_Load     = 1'b0;
    CCR_Load   = 1'b0;
    ALU_Sel    = ALU_ADD;
    Bus1_Sel   = BUS1_PC;
    Bus2_Sel   = BUS2_ALU;
    write      = 1'b0;

    case (state)
      S_FETCH_0:   next_state = S_FETCH_1;
      S_FETCH_1:   next_state = S_FETCH_2;
      S_FETCH_2:   next_state = S_DECODE_3;
      S_DECODE_3: begin
        // Branch conditions are sampled only here; IR is ignored in every other state
        case (IR)
          OP_LDA_IMM: next_state = S_LDA_IMM_4;
          OP_LDA_DIR: next_state = S_LDA_DIR_4;
          OP_LDB_IMM: next_state = S_LDB_IMM_4;
          OP_LDB_DIR: next_state = S_LDB_DIR_4;
          OP_STA_DIR: next_state = S_STA_DIR_4;
          OP_STB_DIR: next_state = S_STB_DIR_4;
          OP_ADD_AB:  next_state = S_ADD_AB_4;
          OP_SUB_AB:  next_state = S_SUB_AB_4;
          OP_AND_AB:  next_state = S_AND_AB_4;
          OP_OR_AB:   next_state = S_OR_AB_4;
          OP_INCA:    next_state = S_INCA_4;
          OP_INCB:    next_state = S_INCB_4;
          OP_DECA:    next_state = S_DECA_4;
          OP_DECB:    next_state = S_DECB_4;
          OP_BRA:     next_state = S_BR_4;
          OP_BMI:     next_state = CCR_Result[3]  ? S_BR_4 : S_BR_NT_4;
          OP_BEQ:     next_state = CCR_Result[2]  ? S_BR_4 : S_BR_NT_4;
          OP_BNE:     next_state = !CCR_Result[2] ? S_BR_4 : S_BR_NT_4;
          OP_BCS:     next_state = CCR_Result[0]  ? S_BR_4 : S_BR_NT_4;
          default:    next_state = S_FETCH_0;
        endcase
      end
      S_LDA_IMM_4: next_state = S_LDA_IMM_5;
      S_LDA_IMM_5: next_state = S_LDA_IMM_6;
      S_LDA_DIR_4: next_state = S_LDA_DIR_5;
      S_LDA_DIR_5: next_state = S_LDA_DIR_6;
      S_LDA_DIR_6: next_state = S_LDA_DIR_7;
      S_LDA_DIR_7: next_state = S_LDA_DIR_8;
      S_LDB_IMM_4: next_state = S_LDB_IMM_5;
      S_LDB_IMM_5: next_state = S_LDB_IMM_6;
      S_LDB_DIR_4: next_state = S_LDB_DIR_5;
      S_LDB_DIR_5: next_state = S_LDB_DIR_6;
      S_LDB_DIR_6: next_state = S_LDB_DIR_7;
      S_LDB_DIR_7: next_state = S_LDB_DIR_8;
      S_STA_DIR_4: next_state = S_STA_DIR_5;
      S_STA_DIR_5: next_state = S_STA_DIR_6;
      S_STA_DIR_6: next_state = S_STA_DIR_7;
      S_STB_DIR_4: next_state = S_STB_DIR_5;
      S_STB_DIR_5: next_state = S_STB_DIR_6;
      S_STB_DIR_6: next_state = S_STB_DIR_7;
      S_BR_4:      next_state = S_BR_5;
      S_BR_5:      next_state = S_BR_6;
      default:     next_state = S_FETCH_0;
    endcase

    case (state)
      S_FETCH_0, S_LDA_IMM_4, S_LDA_DIR_4, S_LDB_IMM_4, S_LDB_DIR_4,
      S_STA_DIR_4, S_STB_DIR_4, S_BR_4: begin
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_BUS1;
        MAR_Load = 1'b1;
      end
      S_FETCH_1, S_LDA_IMM_5, S_LDA_DIR_5, S_LDB_IMM_5, S_LDB_DIR_5,
      S_STA_DIR_5, S_STB_DIR_5, S_BR_NT_4: PC_Inc = 1'b1;
      S_FETCH_2: begin
        Bus2_Sel = BUS2_MEM;
        IR_Load  = 1'b1;
      end
      S_LDA_IMM_6, S_LDA_DIR_8: begin
        Bus2_Sel = BUS2_MEM;
        A_Load   = 1'b1;
      end
      S_LDB_IMM_6, S_LDB_DIR_8: begin
        Bus2_Sel = BUS2_MEM;
        B_Load   = 1'b1;
      end
      // Operand byte holds the direct address; reload MAR from memory
      S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
        Bus2_Sel = BUS2_MEM;
        MAR_Load = 1'b1;
      end
      S_STA_DIR_7: begin
        Bus1_Sel = BUS1_A;
        write    = 1'b1;
      end
      S_STB_DIR_7: begin
        Bus1_Sel = BUS1_B;
        write    = 1'b1;
      end
      S_BR_6: begin
        Bus2_Sel = BUS2_MEM;
        PC_Load  = 1'b1;
      end
      S_ADD_AB_4: begin ALU_Sel = ALU_ADD;  A_Load = 1'b1; CCR_Load = 1'b1; end
      S_SUB_AB_4: begin ALU_Sel = ALU_SUB;  A_Load = 1'b1; CCR_Load = 1'b1; end
      S_AND_AB_4: begin ALU_Sel = ALU_AND;  A_Load = 1'b1; CCR_Load = 1'b1; end
      S_OR_AB_4:  begin ALU_Sel = ALU_OR;   A_Load = 1'b1; CCR_Load = 1'b1; end
      S_INCA_4:   begin ALU_Sel = ALU_INCA; A_Load = 1'b1; CCR_Load = 1'b1; end
      S_DECA_4:   begin ALU_Sel = ALU_DECA; A_Load = 1'b1; CCR_Load = 1'b1; end
      S_INCB_4:   begin ALU_Sel = ALU_INCB; B_Load = 1'b1; CCR_Load = 1'b1; end
      S_DECB_4:   begin ALU_Sel = ALU_DECB; B_Load = 1'b1; CCR_Load = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected output words are queued
// when an instruction is issued and compared against the DUT one cycle at a time.
module tb_control_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0] sb[$];

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
  );

  always #5 Clk = ~Clk;

  // Output word: {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, ALU_Sel, Bus1_Sel, Bus2_Sel, write}
  function automatic logic [14:0] ov(input logic ir, mar, pcl, pci, al, bl, cl,
                                     input logic [2:0] alu, input logic [1:0] b1, b2,
                                     input logic wr);
    return {ir, mar, pcl, pci, al, bl, cl, alu, b1, b2, wr};
  endfunction

  function automatic logic [14:0] dut_word();
    return {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
            ALU_Sel, Bus1_Sel, Bus2_Sel, write};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] op, input logic [3:0] ccr);
    logic [14:0] mar_pc, pc_inc, idle;
    logic taken;
    mar_pc = ov(0,1,0,0,0,0,0,3'b000,2'b00,2'b01,0);
    pc_inc = ov(0,0,0,1,0,0,0,3'b000,2'b00,2'b00,0);
    idle   = '0;
    sb.push_back(mar_pc);
    sb.push_back(pc_inc);
    sb.push_back(ov(1,0,0,0,0,0,0,3'b000,2'b00,2'b10,0));
    sb.push_back(idle);
    case (op)
      8'h86, 8'h88: begin
        sb.push_back(mar_pc);
        sb.push_back(pc_inc);
        sb.push_back(ov(0,0,0,0,op==8'h86,op==8'h88,0,3'b000,2'b00,2'b10,0));
      end
      8'h87, 8'h89: begin
        sb.push_back(mar_pc);
        sb.push_back(pc_inc);
        sb.push_back(ov(0,1,0,0,0,0,0,3'b000,2'b00,2'b10,0));
        sb.push_back(idle);
        sb.push_back(ov(0,0,0,0,op==8'h87,op==8'h89,0,3'b000,2'b00,2'b10,0));
      end
      8'h96, 8'h97: begin
        sb.push_back(mar_pc);
        sb.push_back(pc_inc);
        sb.push_back(ov(0,1,0,0,0,0,0,3'b000,2'b00,2'b10,0));
        sb.push_back(ov(0,0,0,0,0,0,0,3'b000,(op==8'h96) ? 2'b01 : 2'b10,2'b00,1));
      end
      8'h42: sb.push_back(ov(0,0,0,0,1,0,1,3'b000,2'b00,2'b00,0));
      8'h43: sb.push_back(ov(0,0,0,0,1,0,1,3'b001,2'b00,2'b00,0));
      8'h44: sb.push_back(ov(0,0,0,0,1,0,1,3'b010,2'b00,2'b00,0));
      8'h45: sb.push_back(ov(0,0,0,0,1,0,1,3'b011,2'b00,2'b00,0));
      8'h46: sb.push_back(ov(0,0,0,0,1,0,1,3'b100,2'b00,2'b00,0));
      8'h47: sb.push_back(ov(0,0,0,0,0,1,1,3'b110,2'b00,2'b00,0));
      8'h48: sb.push_back(ov(0,0,0,0,1,0,1,3'b101,2'b00,2'b00,0));
      8'h49: sb.push_back(ov(0,0,0,0,0,1,1,3'b111,2'b00,2'b00,0));
      8'h20, 8'h21, 8'h23, 8'h24, 8'h27: begin
        case (op)
          8'h21:   taken = ccr[3];
          8'h23:   taken = ccr[2];
          8'h24:   taken = !ccr[2];
          8'h27:   taken = ccr[0];
          default: taken = 1'b1;
        endcase
        if (taken) begin
          sb.push_back(mar_pc);
          sb.push_back(idle);
          sb.push_back(ov(0,0,1,0,0,0,0,3'b000,2'b00,2'b10,0));
        end else begin
          sb.push_back(pc_inc);
        end
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1 with the FSM in S_FETCH_0; IR/CCR are scrambled except in decode.
  // stop_at > 0 runs only that many cycles and discards the rest of the expectation.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr, input int stop_at);
    int len, ncyc;
    logic [14:0] exp, got;
    push_expected(op, ccr);
    len  = sb.size();
    ncyc = (stop_at > 0) ? stop_at : len;
    for (int c = 1; c <= ncyc; c++) begin
      IR         = (c == 4) ? op  : 8'($urandom);
      CCR_Result = (c == 4) ? ccr : 4'($urandom);
      @(negedge Clk);
      exp = sb.pop_front();
      got = dut_word();
      check($sformatf("op%02h_c%0d", op, c), 32'(got), 32'(exp));
      check($sformatf("op%02h_c%0d_excl", op, c),
            32'((write & PC_Load) | (PC_Load & PC_Inc)), 32'h0);
      @(posedge Clk);
      #1;
    end
    sb.delete();
  endtask

  logic [14:0] f0_word;
  logic [7:0]  ops[$];

  initial begin
    f0_word    = ov(0,1,0,0,0,0,0,3'b000,2'b00,2'b01,0);
    Reset      = 1'b0;
    IR         = 8'h00;
    CCR_Result = 4'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_outputs", 32'(dut_word()), 32'(f0_word));
    @(posedge Clk);
    #1;
    Reset = 1'b1;

    ops = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97,
            8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
            8'hFF, 8'h00};
    foreach (ops[i]) run_instr(ops[i], 4'h0, 0);

    run_instr(8'h20, 4'h0, 0);
    run_instr(8'h21, 4'h8, 0);
    run_instr(8'h21, 4'h7, 0);
    run_instr(8'h23, 4'h4, 0);
    run_instr(8'h23, 4'h0, 0);
    run_instr(8'h24, 4'h0, 0);
    run_instr(8'h24, 4'h4, 0);
    run_instr(8'h27, 4'h1, 0);
    run_instr(8'h27, 4'hE, 0);

    // LDA_DIR interrupted by reset while sitting in its S7 wait state (cycle 8)
    run_instr(8'h87, 4'h0, 7);
    IR = 8'h87;
    #1;
    check("s7_idle", 32'(dut_word()), 32'h0);
    Reset = 1'b0;
    #1;
    check("rst_async", 32'(dut_word()), 32'(f0_word));
    @(negedge Clk);
    check("rst_hold", 32'(dut_word()), 32'(f0_word));
    @(posedge Clk);
    #1;
    check("rst_after_edge", 32'(dut_word()), 32'(f0_word));
    check("rst_no_aload", 32'(A_Load), 32'h0);
    Reset = 1'b1;
    run_instr(8'h86, 4'h0, 0);
    run_instr(8'h43, 4'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all widths and encodings are fixed by this document.
REQ-002 Clk  input  1  rising-edge clock.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 IR  input  8  current instruction register contents from the datapath.
REQ-005 CCR_Result  input  4  datapath condition codes: [3]=N, [2]=Z, [1]=V, [0]=C.
REQ-006 IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  output  1 each  datapath register enables.
REQ-007 ALU_Sel  output  3  ALU operation select.
- Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 INCA, 101 DECA, 110 INCB, 111 DECB.
REQ-008 Bus1_Sel  output  2  Bus1 source: 00 PC, 01 A, 10 B.
REQ-009 Bus2_Sel  output  2  Bus2 source: 00 ALU result, 01 Bus1, 10 from_memory.
REQ-010 write  output  1  memory write strobe; data is Bus1, address is MAR.

Function
REQ-011 Moore FSM: the state register updates on rising Clk; all outputs decode from the current state only.
REQ-012 Any output not listed for a state SHALL be 0; this applies to enables, write, ALU_Sel, Bus1_Sel and Bus2_Sel.
REQ-013 Fetch sequence, common to all instructions:
- S_FETCH_0: Bus1_Sel=00, Bus2_Sel=01, MAR_Load=1.
- S_FETCH_1: PC_Inc=1.
- S_FETCH_2: Bus2_Sel=10, IR_Load=1.
- S_DECODE_3: no outputs; next state chosen from IR.
REQ-014 Opcodes decoded in S_DECODE_3:
- Loads: LDA_IMM 86h, LDA_DIR 87h, LDB_IMM 88h, LDB_DIR 89h.
- Stores: STA_DIR 96h, STB_DIR 97h.
- ALU: ADD_AB 42h, SUB_AB 43h, AND_AB 44h, OR_AB 45h, INCA 46h, INCB 47h, DECA 48h, DECB 49h.
- Branches: BRA 20h, BMI 21h, BEQ 23h, BNE 24h, BCS 27h.
- Any other opcode: treated as NOP; next state is S_FETCH_0.
REQ-015 Immediate load (LDA_IMM / LDB_IMM), 7 cycles total:
- S4: MAR<=PC (Bus1_Sel=00, Bus2_Sel=01, MAR_Load).
- S5: PC_Inc.
- S6: Bus2_Sel=10, A_Load (LDA) or B_Load (LDB).
- Then S_FETCH_0.
REQ-016 Direct load (LDA_DIR / LDB_DIR), 9 cycles total:
- S4: MAR<=PC.
- S5: PC_Inc.
- S6: Bus2_Sel=10, MAR_Load.
- S7: wait; no outputs.
- S8: Bus2_Sel=10, A_Load or B_Load.
- Then S_FETCH_0.
REQ-017 Direct store (STA_DIR / STB_DIR), 8 cycles total:
- S4–S6: as REQ-016.
- S7: Bus1_Sel=01 (STA) or 10 (STB), write=1.
- Then S_FETCH_0.
REQ-018 ALU instructions, 5 cycles total:
- S4: Bus2_Sel=00, ALU_Sel per REQ-007, CCR_Load=1.
- Destination: B_Load for INCB/DECB; A_Load for all others.
- Then S_FETCH_0.
REQ-019 Branch condition (BRA always taken):
- BMI taken if N=1; BEQ if Z=1; BNE if Z=0; BCS if C=1.
- Condition is sampled from CCR_Result in S_DECODE_3.
REQ-020 Branch taken, 7 cycles total:
- S4: MAR<=PC.
- S5: wait.
- S6: Bus2_Sel=10, PC_Load.
- Then S_FETCH_0.
REQ-021 Branch not taken, 5 cycles total:
- S4: PC_Inc, which skips the operand byte.
- Then S_FETCH_0.
REQ-022 write and PC_Load SHALL never be asserted in the same cycle; at most one of PC_Load and PC_Inc is asserted per cycle.
REQ-023 A change of IR outside S_DECODE_3 SHALL NOT alter the state sequence.

Reset
REQ-024 Reset low forces S_FETCH_0 immediately, asynchronously, and from any state, including mid-instruction.
REQ-025 While Reset is low, outputs SHALL be the S_FETCH_0 decode: MAR_Load=1, Bus2_Sel=01, Bus1_Sel=00, all others 0.
REQ-026 The first rising Clk after Reset is released SHALL advance the FSM to S_FETCH_1.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- IR=86h after fetch: IR_Load in cycle 3; MAR_Load in cycle 5; PC_Inc in cycle 6; A_Load with Bus2_Sel=10 in cycle 7; MAR_Load in cycle 8.
- IR=97h: write=1 with Bus1_Sel=10 exactly once, in cycle 8; PC_Load never asserted.
- IR=43h: single cycle with ALU_Sel=001, A_Load=1, CCR_Load=1, Bus2_Sel=00; next fetch starts in cycle 6.
- IR=23h with CCR_Result=0100: PC_Load in cycle 7. IR=23h with CCR_Result=0000: PC_Inc in cycle 5 and no PC_Load.
- IR=FFh: no enables asserted after S_DECODE_3; MAR_Load reasserted in cycle 5.
- Reset pulsed low during S7 of LDA_DIR: outputs immediately match REQ-025; A_Load never asserted; the fetch resumes on release.
